// File: rtl/mio_bus_if.sv
// CPU-side request/response bundle of the memory/IO bus: the controller
// holds a request level, the bus answers with a one-cycle MIO_ready pulse.
interface mio_bus_if;
   logic        MemRead;
   logic        MemWrite;
   logic        CPU_MIO;
   logic [31:0] addr;
   logic [31:0] Data_out;
   logic [31:0] Data_in;
   logic        MIO_ready;

   modport master (
      output MemRead, MemWrite, CPU_MIO, addr, Data_out,
      input  Data_in, MIO_ready
   );

   modport slave (
      input  MemRead, MemWrite, CPU_MIO, addr, Data_out,
      output Data_in, MIO_ready
   );
endinterface

// File: rtl/mio_bus.sv
// Multi-cycle memory/IO bus: IDLE -> WAIT -> ACK, RAM plus LED/switch IO.
// Optional macro MIO_COUNTER_EN adds a free-running counter at 0xF0000008.
module mio_bus #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned RAM_AW      = 10
) (
   input  logic              clk,
   input  logic              reset,
   mio_bus_if.slave          bus,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       sw_in,
   output logic [15:0]       led_out,
   output logic [1:0]        bus_state
);

   // Handshake: a request is a level (CPU_MIO & (MemRead | MemWrite)) sampled
   // only in IDLE; MIO_ready pulses one cycle, the edge after the ACK cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   localparam logic [31:0] IO_LED    = 32'hF000_0000;
   localparam logic [31:0] IO_SW     = 32'hF000_0004;
   localparam logic [31:0] IO_CNT    = 32'hF000_0008;
   localparam logic [3:0]  WAIT_INIT = WAIT_CYCLES[3:0];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic        io_q, io_d;
   logic        ram_we_q, ram_we_d;
   logic        ready_q, ready_d;
   logic [31:0] data_in_q, data_in_d;
   logic [15:0] led_q, led_d;
   logic        req;
   logic        finish;
   logic [31:0] io_rdata;

   assign req    = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
   assign finish = (state_q == S_WAIT) && (cnt_q == 4'd0);

`ifdef MIO_COUNTER_EN
   logic [31:0] free_cnt_q, free_cnt_d;

   always_comb begin
      free_cnt_d = free_cnt_q + 32'd1;
      if (finish && wr_q && io_q && (addr_q == IO_CNT)) free_cnt_d = wdata_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) free_cnt_q <= 32'd0;
      else        free_cnt_q <= free_cnt_d;
   end
`endif

   always_comb begin
      io_rdata = 32'd0;
      case (addr_q)
         IO_LED:  io_rdata = {16'h0000, led_q};
         IO_SW:   io_rdata = {16'h0000, sw_in};
`ifdef MIO_COUNTER_EN
         IO_CNT:  io_rdata = free_cnt_q;
`endif
         default: io_rdata = 32'd0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      io_d      = io_q;
      ram_we_d  = 1'b0;
      ready_d   = (state_q == S_ACK);
      data_in_d = data_in_q;
      led_d     = led_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d   = bus.addr;
               wdata_d  = bus.Data_out;
               wr_d     = bus.MemWrite;
               io_d     = (bus.addr[31:28] == 4'hF);
               cnt_d    = WAIT_INIT;
               // Strobe lands on the first WAIT cycle only.
               ram_we_d = bus.MemWrite & (bus.addr[31:28] != 4'hF);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_ACK;
               if (!wr_q) data_in_d = io_q ? io_rdata : ram_dout;
               else if (io_q && (addr_q == IO_LED)) led_d = wdata_q[15:0];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wr_q      <= 1'b0;
         io_q      <= 1'b0;
         ram_we_q  <= 1'b0;
         ready_q   <= 1'b0;
         data_in_q <= 32'd0;
         led_q     <= 16'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         io_q      <= io_d;
         ram_we_q  <= ram_we_d;
         ready_q   <= ready_d;
         data_in_q <= data_in_d;
         led_q     <= led_d;
      end
   end

   assign ram_addr      = addr_q[RAM_AW+1:2];
   assign ram_din       = wdata_q;
   assign ram_we        = ram_we_q;
   assign led_out       = led_q;
   assign bus_state     = state_q;
   assign bus.Data_in   = data_in_q;
   assign bus.MIO_ready = ready_q;

endmodule

// File: tb/tb_mio_bus.sv
// Directed plus randomized bench for mio_bus against a word-level RAM/IO model.
module tb_mio_bus;
   localparam int W  = 2;
   localparam int AW = 10;
   localparam logic [31:0] A_LED = 32'hF000_0000;
   localparam logic [31:0] A_SW  = 32'hF000_0004;
   localparam logic [31:0] A_CNT = 32'hF000_0008;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;
   logic [15:0]   sw_in;
   logic [15:0]   led_out;
   logic [1:0]    bus_state;

   always #5 clk = ~clk;

   mio_bus_if bus ();

   mio_bus #(.WAIT_CYCLES(W), .RAM_AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .sw_in     (sw_in),
      .led_out   (led_out),
      .bus_state (bus_state)
   );

   // Synchronous RAM with one-cycle read latency.
   logic [31:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   logic [31:0] ram_m [0:(1<<AW)-1];
   logic [15:0] led_m;
   logic [31:0] last_rd;
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_io_read(input logic [31:0] a);
      if (a == A_LED) return {16'h0000, led_m};
      if (a == A_SW)  return {16'h0000, sw_in};
      return 32'd0;
   endfunction

   task automatic drop_req();
      bus.CPU_MIO  = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
   endtask

   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit chkd, output logic [31:0] rdata);
      logic          is_io;
      logic [31:0]   exp_d;
      logic [AW-1:0] idx;
      int            lat;
      int            we_cnt;
      logic [AW-1:0] we_a;
      logic [31:0]   we_dn;
      is_io = (a[31:28] == 4'hF);
      idx   = a[AW+1:2];
      if (wr) begin
         if (is_io && a == A_LED) led_m = d[15:0];
         else if (!is_io) ram_m[idx] = d;
         exp_d = last_rd;
      end else begin
         exp_d = is_io ? model_io_read(a) : ram_m[idx];
         if (chkd) last_rd = exp_d;
      end
      @(negedge clk);
      bus.CPU_MIO = 1'b1; bus.MemRead = rd; bus.MemWrite = wr;
      bus.addr = a; bus.Data_out = d;
      @(posedge clk); #1;
      // Garbage write request held through WAIT must be ignored.
      bus.MemWrite = 1'b1; bus.addr = $urandom; bus.Data_out = $urandom;
      lat = 0; we_cnt = 0; we_a = '0; we_dn = '0;
      chk("first_wait_state", {30'd0, bus_state}, 32'd1);
      while (bus.MIO_ready !== 1'b1 && lat < 20) begin
         if (ram_we === 1'b1) begin we_cnt++; we_a = ram_addr; we_dn = ram_din; end
         if (lat == W + 1) begin
            chk("ack_state", {30'd0, bus_state}, 32'd2);
            chk("led_at_ack", {16'd0, led_out}, {16'd0, led_m});
            drop_req();
         end
         @(posedge clk); #1;
         lat++;
      end
      drop_req();
      chk("ready_latency", lat, W + 2);
      chk("ram_we_cycles", we_cnt, (wr && !is_io) ? 1 : 0);
      if (wr && !is_io) begin
         chk("we_addr", {22'd0, we_a}, {22'd0, idx});
         chk("we_data", we_dn, d);
      end
      chk("ram_addr", {22'd0, ram_addr}, {22'd0, idx});
      if (chkd) chk(wr ? "data_in_hold" : "data_in_read", bus.Data_in, exp_d);
      rdata = bus.Data_in;
      @(posedge clk); #1;
      chk("ready_one_cycle", {31'd0, bus.MIO_ready}, 32'd0);
      chk("back_idle", {30'd0, bus_state}, 32'd0);
      if (!chkd && !wr) last_rd = bus.Data_in;
   endtask

   logic [31:0] rv, v1, v2, a, d;
   logic        r, w;

   initial begin
      drop_req();
      bus.addr = '0; bus.Data_out = '0; sw_in = 16'h0000;
      led_m = 16'd0; last_rd = 32'd0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]   = $urandom;
         ram_m[i] = mem[i];
      end
      mem[4] = 32'h1234_5678; ram_m[4] = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {30'd0, bus_state}, 32'd0);
      chk("rst_ready", {31'd0, bus.MIO_ready}, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_data_in", bus.Data_in, 32'd0);
      chk("rst_led", {16'd0, led_out}, 32'd0);
      chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
      chk("rst_ram_din", ram_din, 32'd0);
      @(negedge clk); reset = 1'b1;

      access(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, rv);
      chk("req18_value", rv, 32'h1234_5678);
      access(1'b0, 1'b1, 32'h0000_001C, 32'hDEAD_BEEF, 1'b1, rv);
      access(1'b1, 1'b0, 32'h0000_001C, 32'd0, 1'b1, rv);
      chk("req19_readback", rv, 32'hDEAD_BEEF);

      access(1'b0, 1'b1, A_LED, 32'h0001_A5A5, 1'b1, rv);
      chk("req20_led", {16'd0, led_out}, 32'h0000_A5A5);
      sw_in = 16'h00FF;
      access(1'b1, 1'b0, A_SW, 32'd0, 1'b1, rv);
      chk("req20_sw", rv, 32'h0000_00FF);
      access(1'b1, 1'b0, A_LED, 32'd0, 1'b1, rv);
      access(1'b0, 1'b1, A_SW, 32'h1111_2222, 1'b1, rv);
      access(1'b0, 1'b1, 32'hF000_0010, 32'h3333_4444, 1'b1, rv);
      access(1'b1, 1'b0, 32'hF000_000C, 32'd0, 1'b1, rv);
      access(1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 1'b1, rv);
      access(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b1, rv);
      chk("rw_is_write", rv, 32'h0BAD_CAFE);

      access(1'b1, 1'b0, A_CNT, 32'd0, 1'b0, v1);
      repeat (4) @(posedge clk);
      access(1'b1, 1'b0, A_CNT, 32'd0, 1'b0, v2);
`ifdef MIO_COUNTER_EN
      chk("cnt_delta", v2 - v1, 32'd10);
      access(1'b0, 1'b1, A_CNT, 32'h8000_0000, 1'b1, rv);
      access(1'b1, 1'b0, A_CNT, 32'd0, 1'b0, rv);
      chk("cnt_load", rv, 32'h8000_0005);
`else
      chk("cnt_off_1", v1, 32'd0);
      chk("cnt_off_2", v2, 32'd0);
`endif

      for (int i = 0; i < 40; i++) begin
         sw_in = 16'($urandom);
         w = 1'($urandom_range(0, 1));
         r = ~w | 1'($urandom_range(0, 1));
         d = $urandom;
         case ($urandom_range(0, 5))
            0:       a = A_LED;
            1:       a = A_SW;
            2:       a = 32'hF000_0000 | (32'($urandom_range(3, 15)) << 2);
            default: a = {4'h0, 20'($urandom), 6'($urandom_range(0, 15)), 2'b00};
         endcase
         access(r, w, a, d, 1'b1, rv);
      end

      // Abort a RAM write mid-WAIT with reset.
      access(1'b0, 1'b1, A_LED, 32'h0000_5A5A, 1'b1, rv);
      access(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, rv);
      @(negedge clk);
      bus.CPU_MIO = 1'b1; bus.MemWrite = 1'b1; bus.MemRead = 1'b0;
      bus.addr = 32'h0000_0040; bus.Data_out = 32'hCAFE_F00D;
      @(posedge clk); #1;
      chk("abort_we_before", {31'd0, ram_we}, 32'd1);
      #2 reset = 1'b0;
      #1;
      drop_req();
      led_m = 16'd0; last_rd = 32'd0;
      chk("abort_we_async", {31'd0, ram_we}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_we", {31'd0, ram_we}, 32'd0);
         chk("abort_state", {30'd0, bus_state}, 32'd0);
         chk("abort_led", {16'd0, led_out}, 32'd0);
      end
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("abort_no_ready", {31'd0, bus.MIO_ready}, 32'd0);
         chk("abort_idle", {30'd0, bus_state}, 32'd0);
      end
      chk("abort_data_in", bus.Data_in, 32'd0);
      access(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b1, rv);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
